// File: rtl/tohost_ctrl_pkg.sv
// Shared definitions for the tohost controller: register word offsets,
// STATUS bit positions, run-state encodings and the STATUS packing helper.
package tohost_ctrl_pkg;

  localparam logic [1:0] REG_TOHOST  = 2'd0;
  localparam logic [1:0] REG_CONSOLE = 2'd1;
  localparam logic [1:0] REG_CYCLE   = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int STATUS_DONE    = 0;
  localparam int STATUS_PASS    = 1;
  localparam int STATUS_TIMEOUT = 2;
  localparam int STATUS_FULL    = 3;
  localparam int STATUS_EMPTY   = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } run_state_e;

  function automatic logic [31:0] status_word(input logic done, input logic pass,
                                              input logic timeout, input logic full,
                                              input logic empty);
    logic [31:0] w_word;
    w_word                 = '0;
    w_word[STATUS_DONE]    = done;
    w_word[STATUS_PASS]    = pass;
    w_word[STATUS_TIMEOUT] = timeout;
    w_word[STATUS_FULL]    = full;
    w_word[STATUS_EMPTY]   = empty;
    return w_word;
  endfunction

endpackage

// File: rtl/tohost_ctrl_if.sv
// Request/response bus between a test harness master and the tohost controller.
interface tohost_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/tohost_fifo.sv
// Synchronous FIFO with power-of-two depth; the head reads as zero when empty
// so downstream data lines sit at a known value out of reset.
module tohost_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tohost_ctrl.sv
// Test-harness tohost controller: pass/fail capture, cycle watchdog and an
// optional console byte FIFO enabled by defining TOHOST_CONSOLE_EN.
module tohost_ctrl
  import tohost_ctrl_pkg::*;
#(
  parameter int TIMEOUT_LOG2 = 20,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tohost_ctrl_if.slave        bus,
  output logic                done_o,
  output logic                pass_o,
  output logic [30:0]         fail_num_o,
  output logic                timeout_o,
  output logic [31:0]         cycle_o,
  output logic                char_valid_o,
  output logic [7:0]          char_data_o,
  input  logic                char_ready_i
);

  run_state_e  r_state;
  run_state_e  w_state_next;
  logic [31:0] r_cycle;
  logic [31:0] r_tohost;
  logic        r_pass;
  logic [30:0] r_fail_num;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;

  logic [1:0]  w_reg;
  logic        w_accept;
  logic        w_tohost_wr;
  logic        w_console_wr;
  logic        w_done_hit;
  logic        w_wd_hit;
  logic [31:0] w_cycle_next;
  logic [31:0] w_rdata;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [31:0] w_console_free;
  logic        w_unused_addr;

  assign w_reg         = bus.req_addr[3:2];
  assign w_unused_addr = ^bus.req_addr[1:0];
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_tohost_wr   = w_accept && bus.req_we && (w_reg == REG_TOHOST);
  assign w_console_wr  = w_accept && bus.req_we && (w_reg == REG_CONSOLE);
  assign w_done_hit    = w_tohost_wr && bus.req_wdata[0];
  // Watchdog looks at the value the counter is about to take, so timeout_o
  // rises together with the counter bit and the count freezes on that value.
  assign w_cycle_next  = r_cycle + 32'd1;
  assign w_wd_hit      = w_cycle_next[TIMEOUT_LOG2];

`ifdef TOHOST_CONSOLE_EN
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

  tohost_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_console_wr),
    .i_data  (bus.req_wdata[7:0]),
    .i_pop   (char_ready_i),
    .o_data  (char_data_o),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign char_valid_o   = !w_fifo_empty;
  assign w_console_free = 32'(FIFO_DEPTH) - 32'(w_fifo_count);
  // A console push against a full FIFO stalls even if a pop happens this cycle.
  assign bus.req_ready  = !(bus.req_valid && bus.req_we &&
                            (w_reg == REG_CONSOLE) && w_fifo_full);
`else
  logic w_unused_console;

  assign w_unused_console = char_ready_i ^ w_console_wr;
  assign w_fifo_full      = 1'b0;
  assign w_fifo_empty     = 1'b1;
  assign w_console_free   = '0;
  assign char_valid_o     = 1'b0;
  assign char_data_o      = '0;
  assign bus.req_ready    = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // A done write beats a simultaneous watchdog expiry; both end states are terminal.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_done_hit)    w_state_next = ST_DONE;
        else if (w_wd_hit) w_state_next = ST_TIMEOUT;
      end
      default: w_state_next = r_state;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_TOHOST:  w_rdata = r_tohost;
      REG_CONSOLE: w_rdata = w_console_free;
      REG_CYCLE:   w_rdata = r_cycle;
      REG_STATUS:  w_rdata = status_word(done_o, pass_o, timeout_o,
                                         w_fifo_full, w_fifo_empty);
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle     <= '0;
      r_tohost    <= '0;
      r_pass      <= 1'b0;
      r_fail_num  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (r_state == ST_RUN) r_cycle <= w_cycle_next;
      if (r_state == ST_RUN && w_tohost_wr) r_tohost <= bus.req_wdata;
      if (r_state == ST_RUN && w_done_hit) begin
        r_pass     <= (bus.req_wdata == 32'd1);
        r_fail_num <= bus.req_wdata[31:1];
      end
      r_rsp_valid <= w_accept;
      r_rsp_rdata <= (w_accept && !bus.req_we) ? w_rdata : '0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign done_o        = (r_state == ST_DONE);
  assign timeout_o     = (r_state == ST_TIMEOUT);
  assign pass_o        = r_pass;
  assign fail_num_o    = r_fail_num;
  assign cycle_o       = r_cycle;

endmodule
